// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter
// Shares one read port of the sprite colour RAM between NUM_REQ pixel-pipeline
// requesters. Arbitration is round-robin, and a requester can hold locked bursts
// of up to MAX_BURST grants. Every issued read carries a one-hot requester tag
// through a RAM_LAT+1 deep pipeline, so the returned word reaches the requester
// that asked for it.
//
// Optional feature: define SPRITE_ARB_PRIO0_EN to give requester 0 (Pac-Man)
// absolute priority. When it is defined, req[0] wins every cycle and pre-empts
// any other owner's burst. When it is undefined, arbitration is pure round-robin.
//
// Latency: gnt in cycle C -> ram_rd/ram_addr in C+1 -> ram_data in C+1+RAM_LAT
//          -> rd_valid/rd_data in C+2+RAM_LAT.

module sprite_fetch_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 24,
    parameter int RAM_LAT   = 1,
    parameter int MAX_BURST = 26
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_rd,
    input  logic [DATA_W-1:0]         ram_data,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int TAG_D = RAM_LAT + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    // Arbitration state. In BURST, r_ptr also names the burst owner, because
    // the pointer always moves to the most recent winner.
    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;

    // Arbitration decision for the current cycle
    logic               w_cont;
    logic               w_prio;
    logic               w_any;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W:0]     w_cand;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0]  w_sel_addr;

    // RAM issue and return registers
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_rd;
    logic [NUM_REQ-1:0] r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;

    // Tag pipeline: stage k holds the requester whose read was issued k+1 cycles ago
    logic [NUM_REQ-1:0] r_tag_id [TAG_D];
    logic [TAG_D-1:0]   r_tag_v;

    // Arbitration state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Winner selection and next-state: burst continuation, else round-robin search
    always_comb begin
        w_cont = (r_state == S_BURST) && req[r_ptr] && lock[r_ptr] &&
                 (r_count < CNT_W'(MAX_BURST));

`ifdef SPRITE_ARB_PRIO0_EN
        // Requester 0 wins whenever it asks, unless it is already the continuing owner
        w_prio = req[0] && !(w_cont && (r_ptr == {IDX_W{1'b0}}));
`else
        w_prio = 1'b0;
`endif

        w_any    = 1'b0;
        w_winner = r_ptr;
        w_cand   = {(IDX_W+1){1'b0}};

        if (w_prio) begin
            w_any    = 1'b1;
            w_winner = {IDX_W{1'b0}};
        end else if (w_cont) begin
            w_any    = 1'b1;
            w_winner = r_ptr;
        end else begin
            // The loop runs from the farthest candidate to the nearest one, so the
            // last match is the first requester after the pointer. The current
            // pointer is searched last.
            for (int k = NUM_REQ; k >= 1; k--) begin
                w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
                if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                    w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
                end else begin
                    w_cand = w_cand;
                end
                if (req[w_cand[IDX_W-1:0]]) begin
                    w_any    = 1'b1;
                    w_winner = w_cand[IDX_W-1:0];
                end else begin
                    w_any    = w_any;
                    w_winner = w_winner;
                end
            end
        end

        if (w_any) begin
            w_ptr_nxt   = w_winner;
            w_count_nxt = (w_cont && !w_prio) ? (r_count + CNT_W'(1)) : CNT_W'(1);
            w_state_nxt = lock[w_winner] ? S_BURST : S_IDLE;
        end else begin
            w_ptr_nxt   = r_ptr;
            w_count_nxt = {CNT_W{1'b0}};
            w_state_nxt = S_IDLE;
        end
    end

    // Grant decode and address mux; the grant is suppressed while Reset is high
    always_comb begin
        w_gnt = {NUM_REQ{1'b0}};
        if (w_any && !Reset) begin
            w_gnt[w_winner] = 1'b1;
        end else begin
            w_gnt = {NUM_REQ{1'b0}};
        end
        w_sel_addr = addr_in[w_winner*ADDR_W +: ADDR_W];
    end

    // RAM issue: register the granted address, and hold the address when idle
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ram_rd   <= 1'b0;
            r_ram_addr <= {ADDR_W{1'b0}};
        end else begin
            r_ram_rd <= w_any;
            if (w_any) begin
                r_ram_addr <= w_sel_addr;
            end else begin
                r_ram_addr <= r_ram_addr;
            end
        end
    end

    // Tag pipeline: move each requester ID alongside its read; reset drops in-flight reads
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_tag_v <= {TAG_D{1'b0}};
            for (int k = 0; k < TAG_D; k++) begin
                r_tag_id[k] <= {NUM_REQ{1'b0}};
            end
        end else begin
            r_tag_v[0]  <= w_any;
            r_tag_id[0] <= w_gnt;
            for (int k = 1; k < TAG_D; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
        end
    end

    // Return stage: capture RAM data when the final tag is valid, and strobe its owner
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_valid <= {NUM_REQ{1'b0}};
            r_rd_data  <= {DATA_W{1'b0}};
        end else begin
            if (r_tag_v[TAG_D-1]) begin
                r_rd_valid <= r_tag_id[TAG_D-1];
                r_rd_data  <= ram_data;
            end else begin
                r_rd_valid <= {NUM_REQ{1'b0}};
                r_rd_data  <= r_rd_data;
            end
        end
    end

    assign gnt      = w_gnt;
    assign ram_addr = r_ram_addr;
    assign ram_rd   = r_ram_rd;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
